// File: rtl/add_sched_pkg.sv
// Shared constants and the in-flight tag record for the add_block issue scheduler.
package add_sched_pkg;

  localparam int unsigned REG_ADDR_W   = 4;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned ADD_LATENCY  = 4;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            req_id;
    logic [REG_ADDR_W-1:0] dest;
  } tag_t;

endpackage

// File: rtl/add_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      idx = PTR_W'((int'(ptr) + off) % int'(NUM_REQ));
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_issue_sched.sv
// Issue scheduler sharing one add_block between requesters, with register scoreboard and tag pipe.
// Define ADD_SCHED_PERF_EN to add saturating issue/stall performance counters.
module add_issue_sched
  import add_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned LATENCY  = ADD_LATENCY,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]     req_src_a,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]     req_src_b,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]     req_dest,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   issue_valid,
  output logic [REG_ADDR_W-1:0]                  issue_src_a,
  output logic [REG_ADDR_W-1:0]                  issue_src_b,
  output logic [REG_ADDR_W-1:0]                  issue_dest,
  input  logic                                   wb_enable,
  input  logic [REG_ADDR_W-1:0]                  wb_dest,
  output logic [ID_W-1:0]                        wb_req_id,
  output logic [NUM_REGS-1:0]                    pending,
  output logic                                   err_sticky
`ifdef ADD_SCHED_PERF_EN
  ,
  output logic [31:0]                            perf_issue_cnt,
  output logic [31:0]                            perf_stall_cnt
`endif
);

  logic [NUM_REQ-1:0]    eligible, grant;
  logic                  hs;
  logic [ID_W-1:0]       gnt_id, rr_q, rr_d, id_q;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  issue_valid_q;
  logic [REG_ADDR_W-1:0] src_a_q, src_b_q, dest_q;
  tag_t [LATENCY-1:0]    tag_q;
  tag_t                  tail, new_tag;
  logic                  err_q, err_d;

  // Hazard check uses registered pending only: a same-cycle writeback does not unblock.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = req_valid[i] & ~pending_q[req_src_a[i]] & ~pending_q[req_src_b[i]]
                    & ~pending_q[req_dest[i]];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_q),
    .grant (grant)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) gnt_id = ID_W'(i);
    end
  end

  assign hs   = |grant;
  assign rr_d = !hs ? rr_q : (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  // Set is applied after clear so an issue wins over a same-register writeback.
  always_comb begin
    pending_d = pending_q;
    if (wb_enable) pending_d[wb_dest] = 1'b0;
    if (hs) pending_d[req_dest[gnt_id]] = 1'b1;
  end

  assign tail    = tag_q[LATENCY-1];
  assign new_tag = '{valid: issue_valid_q, req_id: 2'(id_q), dest: dest_q};
  assign err_d   = err_q | (wb_enable != tail.valid)
                 | (wb_enable & ((wb_dest != tail.dest) | ~pending_q[wb_dest]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q          <= '0;
      pending_q     <= '0;
      issue_valid_q <= 1'b0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      dest_q        <= '0;
      id_q          <= '0;
      tag_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      pending_q     <= pending_d;
      issue_valid_q <= hs;
      err_q         <= err_d;
      if (hs) begin
        src_a_q <= req_src_a[gnt_id];
        src_b_q <= req_src_b[gnt_id];
        dest_q  <= req_dest[gnt_id];
        id_q    <= gnt_id;
      end
      tag_q[0] <= new_tag;
      for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign req_ready   = grant;
  assign issue_valid = issue_valid_q;
  assign issue_src_a = src_a_q;
  assign issue_src_b = src_b_q;
  assign issue_dest  = dest_q;
  assign wb_req_id   = ID_W'(tail.req_id);
  assign pending     = pending_q;
  assign err_sticky  = err_q;

`ifdef ADD_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hs && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && !hs && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
